// File: rtl/mdu_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
// Used by the datapath and by anything that drives op.
package mdu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StMult,
        StDiv,
        StFix,
        StDone
    } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Signed multiply (radix-2 Booth) and divide (restoring, on magnitudes) unit.
// Both algorithms handle one bit per cycle. HI/LO hold their value until the next operation finishes.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = mdu_pkg::WIDTH,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef struct packed {
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
    } div_step_t;

    // One restoring step: shift the next dividend bit into the remainder, then subtract if it fits.
    function automatic div_step_t div_step(input logic [WIDTH-1:0] rem,
                                           input logic [WIDTH-1:0] quo,
                                           input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] trial;
        div_step_t      res;
        trial   = {rem, quo[WIDTH-1]};
        res.quo = {quo[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, dvs}) begin
            trial      = trial - {1'b0, dvs};
            res.quo[0] = 1'b1;
        end
        res.rem = trial[WIDTH-1:0];
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    // Booth upper half carries one extra bit so a multiplicand of -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]   up_q, up_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic             qm1_q, qm1_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic             accept;
    logic             b_zero;
    logic             last;
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_up;
    logic [WIDTH-1:0] booth_low;
    div_step_t        dstep;

    assign accept = start && ((state_q == StIdle) || (state_q == StDone));
    assign b_zero = (b == '0);
    assign last   = (cnt_q == 6'(ITER - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (op == OP_MULT) begin
                        state_d = StMult;
                    end else if (b_zero) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDiv;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StMult:  state_d = last ? StDone : StMult;
            StDiv:   state_d = last ? StFix : StDiv;
            StFix:   state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state_q == StMult) || (state_q == StDiv) || (state_q == StFix);
        done     = (state_q == StDone);
        div_zero = div_zero_q;
        hi       = hi_q;
        lo       = lo_q;
    end

    // Booth step: inspect {multiplier lsb, previous lsb}, add/subtract, then arithmetic shift right.
    always_comb begin
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        booth_sum = up_q;
        case ({low_q[0], qm1_q})
            2'b01:   booth_sum = up_q + mcand_ext;
            2'b10:   booth_sum = up_q - mcand_ext;
            default: booth_sum = up_q;
        endcase
        booth_up  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_low = {booth_sum[0], low_q[WIDTH-1:1]};
        dstep     = div_step(up_q[WIDTH-1:0], low_q, mcand_q);
    end

    // Datapath next-state
    always_comb begin
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        up_d       = up_q;
        low_d      = low_q;
        qm1_d      = qm1_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        if (accept) begin
            cnt_d      = '0;
            up_d       = '0;
            qm1_d      = 1'b0;
            div_zero_d = 1'b0;
            if (op == OP_MULT) begin
                mcand_d = a;
                low_d   = b;
            end else begin
                mcand_d    = abs_val(b);
                low_d      = abs_val(a);
                qneg_d     = a[WIDTH-1] ^ b[WIDTH-1];
                rneg_d     = a[WIDTH-1];
                div_zero_d = b_zero;
            end
        end else begin
            case (state_q)
                StMult: begin
                    up_d  = booth_up;
                    low_d = booth_low;
                    qm1_d = low_q[0];
                    cnt_d = last ? '0 : cnt_q + 6'd1;
                    if (last) begin
                        hi_d = booth_up[WIDTH-1:0];
                        lo_d = booth_low;
                    end
                end
                StDiv: begin
                    up_d  = {1'b0, dstep.rem};
                    low_d = dstep.quo;
                    cnt_d = last ? '0 : cnt_q + 6'd1;
                end
                StFix: begin
                    lo_d = qneg_q ? (~low_q + 1'b1) : low_q;
                    hi_d = rneg_q ? (~up_q[WIDTH-1:0] + 1'b1) : up_q[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            mcand_q    <= '0;
            up_q       <= '0;
            low_q      <= '0;
            qm1_q      <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            up_q       <= up_d;
            low_q      <= low_d;
            qm1_q      <= qm1_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results, div-by-zero,
// asynchronous reset abort, ignored start while busy and back-to-back issue.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int nbusy;
    int dones;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
    endtask

    // Start is high for exactly one edge (edge k); returns at the negedge after edge k.
    task automatic start_op(input logic o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        issue(o, va, vb);
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
    endtask

    // n = edges after edge k until done is seen; optionally pokes a DIV start at cycle poke_at.
    task automatic wait_done(output int n, output int nb, input int poke_at,
                             input logic [31:0] pa, input logic [31:0] pb);
        n  = 0;
        nb = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (n == poke_at) issue(OP_DIV, pa, pb);
            else start = 1'b0;
            if (busy) nb++;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dz", 64'(div_zero), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        // 7 * -3 = -21
        start_op(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        check_eq("m1_busy0", 64'(busy), 64'd1);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("m1_lat", 64'(lat), 64'd32);
        check_eq("m1_nbusy", 64'(nbusy), 64'd32);
        check_eq("m1_hi", 64'(hi), 64'hFFFF_FFFF);
        check_eq("m1_lo", 64'(lo), 64'hFFFF_FFEB);
        @(negedge clk);
        check_eq("m1_done_1cyc", 64'(done), 64'd0);

        // -2^31 * -2^31 = 2^62
        start_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("m2_lat", 64'(lat), 64'd32);
        check_eq("m2_hi", 64'(hi), 64'h4000_0000);
        check_eq("m2_lo", 64'(lo), 64'h0000_0000);

        // -7 / 2 = -3 rem -1
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check_eq("d1_hi_stable", 64'(hi), 64'h4000_0000);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("d1_lat", 64'(lat), 64'd33);
        check_eq("d1_nbusy", 64'(nbusy), 64'd33);
        check_eq("d1_lo", 64'(lo), 64'hFFFF_FFFD);
        check_eq("d1_hi", 64'(hi), 64'hFFFF_FFFF);
        check_eq("d1_dz", 64'(div_zero), 64'd0);

        // 7 / -2 = -3 rem 1
        start_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("d2_lo", 64'(lo), 64'hFFFF_FFFD);
        check_eq("d2_hi", 64'(hi), 64'd1);

        // Overflow wraps: -2^31 / -1
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("dov_lo", 64'(lo), 64'h8000_0000);
        check_eq("dov_hi", 64'(hi), 64'd0);

        // Divide by zero keeps hi/lo from the preceding 3*5
        start_op(OP_MULT, 32'd3, 32'd5);
        wait_done(lat, nbusy, -1, '0, '0);
        start_op(OP_DIV, 32'd9, 32'd0);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("dz_lat", 64'(lat), 64'd0);
        check_eq("dz_done", 64'(done), 64'd1);
        check_eq("dz_flag", 64'(div_zero), 64'd1);
        check_eq("dz_hi", 64'(hi), 64'd0);
        check_eq("dz_lo", 64'(lo), 64'd15);
        @(negedge clk);
        check_eq("dz_sticky", 64'(div_zero), 64'd1);
        start_op(OP_MULT, 32'd2, 32'd3);
        check_eq("dz_cleared", 64'(div_zero), 64'd0);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("m3_lo", 64'(lo), 64'd6);

        // Asynchronous reset ten cycles into a multiply
        start_op(OP_MULT, 32'd100, 32'd100);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_busy", 64'(busy), 64'd0);
        check_eq("ar_hi", 64'(hi), 64'd0);
        check_eq("ar_lo", 64'(lo), 64'd0);
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("ar_no_done", 64'(dones), 64'd0);
        reset = 1'b1;

        // Start while busy is ignored (a 1/0 divide would otherwise flag div_zero)
        start_op(OP_MULT, 32'd100, 32'd100);
        wait_done(lat, nbusy, 5, 32'd1, 32'd0);
        check_eq("ig_lat", 64'(lat), 64'd32);
        check_eq("ig_lo", 64'(lo), 64'd10000);
        check_eq("ig_hi", 64'(hi), 64'd0);
        check_eq("ig_dz", 64'(div_zero), 64'd0);

        // Back-to-back: DIV issued in the DONE cycle of a MULT
        start_op(OP_MULT, 32'd4, 32'd5);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("bb_mlo", 64'(lo), 64'd20);
        issue(OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        check_eq("bb_busy", 64'(busy), 64'd1);
        check_eq("bb_nodone", 64'(done), 64'd0);
        wait_done(lat, nbusy, -1, '0, '0);
        check_eq("bb_lat", 64'(lat), 64'd33);
        check_eq("bb_lo", 64'(lo), 64'd14);
        check_eq("bb_hi", 64'(hi), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
